// File: rtl/instruction_fetch_queue_if.sv
// Fetch-stage bus bundle: program-memory read port plus the decode valid/ready handshake.
// master = fetch stage, slave = memory/decode side.
interface instruction_fetch_queue_if #(
    parameter int unsigned NB_ADDR = 32,
    parameter int unsigned NB_DATA = 32
);
    logic [NB_ADDR-1:0] o_mem_addr;
    logic               o_mem_rd_en;
    logic [NB_DATA-1:0] i_mem_data;
    logic [NB_DATA-1:0] o_inst;
    logic [NB_ADDR-1:0] o_inst_pc_next;
    logic               o_inst_valid;
    logic               i_inst_ready;

    modport master (
        output o_mem_addr, o_mem_rd_en, o_inst, o_inst_pc_next, o_inst_valid,
        input  i_mem_data, i_inst_ready
    );

    modport slave (
        input  o_mem_addr, o_mem_rd_en, o_inst, o_inst_pc_next, o_inst_valid,
        output i_mem_data, i_inst_ready
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Decoupled fetch: issues 1-cycle-latency memory reads into a PC-tagged FIFO, read issued at N is valid at N+2.
// Backpressure: reads only issue while queue level + in-flight read leaves a free slot; decode stalls via i_inst_ready.
module instruction_fetch_queue #(
    parameter int unsigned         NB_ADDR     = 32,
    parameter int unsigned         NB_DATA     = 32,
    parameter int unsigned         PC_STEP     = 4,
    parameter logic [NB_ADDR-1:0]  RESET_PC    = '0,
    parameter int unsigned         QUEUE_DEPTH = 4,
    parameter int unsigned         NB_QLVL     = 3,
    parameter logic [NB_DATA-1:0]  HALT_WORD   = '0
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_redirect,
    input  logic [NB_ADDR-1:0]     i_redirect_addr,
    output logic                   o_halted,
    output logic [NB_QLVL-1:0]     o_queue_level,
    instruction_fetch_queue_if.master bus
);
    localparam int unsigned        NB_PTR = NB_QLVL - 1;
    localparam logic [NB_ADDR-1:0] STEP   = NB_ADDR'(PC_STEP);

    typedef enum logic {ST_FETCH = 1'b0, ST_HALTED = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [NB_ADDR-1:0]   pc_q, pc_d;
    logic [NB_ADDR-1:0]   tag_q, tag_d;
    logic                 inflight_q, inflight_d;
    logic [NB_QLVL-1:0]   wr_ptr_q, wr_ptr_d;
    logic [NB_QLVL-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NB_DATA-1:0]   last_inst_q, last_inst_d;
    logic [NB_ADDR-1:0]   last_pcn_q, last_pcn_d;
    logic [NB_DATA-1:0]   q_inst_q [QUEUE_DEPTH];
    logic [NB_ADDR-1:0]   q_pcn_q  [QUEUE_DEPTH];

    logic [NB_QLVL-1:0]   level;
    logic [NB_PTR-1:0]    wr_idx, rd_idx;
    logic                 q_empty, credit_ok, issue, enq, deq, halt_hit, inst_vld;

    assign level     = wr_ptr_q - rd_ptr_q;
    assign q_empty   = (level == '0);
    assign wr_idx    = wr_ptr_q[NB_PTR-1:0];
    assign rd_idx    = rd_ptr_q[NB_PTR-1:0];
    // Credit counts the outstanding read but not a same-cycle dequeue.
    assign credit_ok = (({1'b0, level} + (NB_QLVL+1)'(inflight_q)) < (NB_QLVL+1)'(QUEUE_DEPTH));
    assign issue     = (state_q == ST_FETCH) && i_enable && !i_redirect && credit_ok;
    assign enq       = inflight_q && !i_redirect && (state_q == ST_FETCH);
    assign halt_hit  = enq && (bus.i_mem_data == HALT_WORD);
    assign inst_vld  = !q_empty && !i_redirect;
    assign deq       = inst_vld && bus.i_inst_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tag_d       = tag_q;
        inflight_d  = issue;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_inst_d = last_inst_q;
        last_pcn_d  = last_pcn_q;
        if (i_redirect) begin
            rd_ptr_d = wr_ptr_q;
            pc_d     = i_redirect_addr;
            state_d  = ST_FETCH;
        end else begin
            // On a halt hit the PC stays just past the halt word even if a read issues now.
            if (issue) begin
                tag_d = pc_q;
                if (!halt_hit) pc_d = pc_q + STEP;
            end
            if (enq) wr_ptr_d = wr_ptr_q + NB_QLVL'(1);
            if (deq) begin
                rd_ptr_d    = rd_ptr_q + NB_QLVL'(1);
                last_inst_d = q_inst_q[rd_idx];
                last_pcn_d  = q_pcn_q[rd_idx];
            end
            if (halt_hit) state_d = ST_HALTED;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            tag_q       <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_inst_q <= '0;
            last_pcn_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tag_q       <= tag_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_inst_q <= last_inst_d;
            last_pcn_q  <= last_pcn_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (enq) begin
            q_inst_q[wr_idx] <= bus.i_mem_data;
            q_pcn_q[wr_idx]  <= tag_q + STEP;
        end
    end

    assign bus.o_mem_addr     = pc_q;
    assign bus.o_mem_rd_en    = issue;
    assign bus.o_inst_valid   = inst_vld;
    assign bus.o_inst         = q_empty ? last_inst_q : q_inst_q[rd_idx];
    assign bus.o_inst_pc_next = q_empty ? last_pcn_q  : q_pcn_q[rd_idx];
    assign o_halted           = (state_q == ST_HALTED);
    assign o_queue_level      = level;
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: per-cycle vector table plus hand sequences for stall, redirect, reset and PC wrap.
module tb_instruction_fetch_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n;
    logic        enable, redirect, enable2, redirect2;
    logic [31:0] raddr;
    logic [7:0]  raddr2;
    logic        halted, halted2;
    logic [2:0]  level, level2;
    logic [31:0] halt_addr;

    int checks = 0;
    int errors = 0;

    instruction_fetch_queue_if #(.NB_ADDR(32), .NB_DATA(32)) bus1 ();
    instruction_fetch_queue_if #(.NB_ADDR(8),  .NB_DATA(32)) bus2 ();

    instruction_fetch_queue dut (
        .i_clock(clk), .i_reset(rst_n), .i_enable(enable), .i_redirect(redirect),
        .i_redirect_addr(raddr), .o_halted(halted), .o_queue_level(level), .bus(bus1)
    );

    instruction_fetch_queue #(.NB_ADDR(8), .RESET_PC(8'hFC)) dut2 (
        .i_clock(clk), .i_reset(rst2_n), .i_enable(enable2), .i_redirect(redirect2),
        .i_redirect_addr(raddr2), .o_halted(halted2), .o_queue_level(level2), .bus(bus2)
    );

    function automatic logic [31:0] mem1(input logic [31:0] a);
        if (a == halt_addr) return 32'h0;
        if (a < 32'd12)     return 32'h11 * (a / 4 + 1);
        return 32'hC000_0000 | a;
    endfunction

    always @(posedge clk) if (bus1.o_mem_rd_en) bus1.i_mem_data <= mem1(bus1.o_mem_addr);
    always @(posedge clk) if (bus2.o_mem_rd_en) bus2.i_mem_data <= 32'hD000_0000 | 32'(bus2.o_mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rdy, input logic en, input logic rd, input logic [31:0] ra);
        @(negedge clk);
        bus1.i_inst_ready = rdy;
        enable = en;
        redirect = rd;
        raddr = ra;
        #1;
    endtask

    typedef struct {
        logic rdy, en, rd;
        logic [31:0] ra;
        logic e_rd;
        logic [31:0] e_addr;
        logic e_vld;
        logic [31:0] e_inst, e_pcn;
        logic [2:0] e_lvl;
        logic e_halt;
    } vec_t;

    function automatic vec_t mk(input logic rdy, en, rd, input logic [31:0] ra,
                                input logic e_rd, input logic [31:0] e_addr, input logic e_vld,
                                input logic [31:0] e_inst, e_pcn, input logic [2:0] e_lvl,
                                input logic e_halt);
        vec_t v;
        v.rdy = rdy; v.en = en; v.rd = rd; v.ra = ra;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_inst = e_inst; v.e_pcn = e_pcn; v.e_lvl = e_lvl; v.e_halt = e_halt;
        return v;
    endfunction

    vec_t tbl [13];
    int   nrd;
    logic [31:0] last_rd_addr;

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t, required finish before 200000", $time);
        $fatal(1);
    end

    initial begin
        // Startup through halt, then idle in HALTED, then redirect out of it.
        tbl[0]  = mk(1,1,0,0,     1,32'h00,0,32'h00,32'h00,0,0);
        tbl[1]  = mk(1,1,0,0,     1,32'h04,0,32'h00,32'h00,0,0);
        tbl[2]  = mk(1,1,0,0,     1,32'h08,1,32'h11,32'h04,1,0);
        tbl[3]  = mk(1,1,0,0,     1,32'h0C,1,32'h22,32'h08,1,0);
        tbl[4]  = mk(1,1,0,0,     1,32'h10,1,32'h33,32'h0C,1,0);
        tbl[5]  = mk(1,1,0,0,     0,32'h10,1,32'h00,32'h10,1,1);
        tbl[6]  = mk(1,1,0,0,     0,32'h10,0,32'h00,32'h10,0,1);
        tbl[7]  = mk(1,0,0,0,     0,32'h10,0,32'h00,32'h10,0,1);
        tbl[8]  = mk(1,1,0,0,     0,32'h10,0,32'h00,32'h10,0,1);
        tbl[9]  = mk(1,1,1,32'h40,0,32'h10,0,32'h00,32'h10,0,1);
        tbl[10] = mk(1,1,0,0,     1,32'h40,0,32'h00,32'h10,0,0);
        tbl[11] = mk(1,1,0,0,     1,32'h44,0,32'h00,32'h10,0,0);
        tbl[12] = mk(1,1,0,0,     1,32'h48,1,32'hC000_0040,32'h44,1,0);

        halt_addr = 32'd12;
        rst_n = 1'b0; rst2_n = 1'b0;
        enable = 1'b0; redirect = 1'b0; raddr = '0;
        enable2 = 1'b0; redirect2 = 1'b0; raddr2 = '0;
        bus1.i_inst_ready = 1'b0; bus2.i_inst_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_rd_en",  32'(bus1.o_mem_rd_en), 0);
        chk("rst_addr",   bus1.o_mem_addr, 0);
        chk("rst_valid",  32'(bus1.o_inst_valid), 0);
        chk("rst_inst",   bus1.o_inst, 0);
        chk("rst_pcn",    bus1.o_inst_pc_next, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_level",  32'(level), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].rdy, tbl[i].en, tbl[i].rd, tbl[i].ra);
            chk($sformatf("v%0d_rd_en", i),  32'(bus1.o_mem_rd_en), 32'(tbl[i].e_rd));
            chk($sformatf("v%0d_addr", i),   bus1.o_mem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_valid", i),  32'(bus1.o_inst_valid), 32'(tbl[i].e_vld));
            chk($sformatf("v%0d_inst", i),   bus1.o_inst, tbl[i].e_inst);
            chk($sformatf("v%0d_pcn", i),    bus1.o_inst_pc_next, tbl[i].e_pcn);
            chk($sformatf("v%0d_level", i),  32'(level), 32'(tbl[i].e_lvl));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(tbl[i].e_halt));
        end
        halt_addr = 32'hFFFF_FFF0;

        // Decode stalled: queue fills to exactly 4, then one dequeue frees exactly one read.
        cyc(0,1,1,32'h200);
        nrd = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0,1,0,0);
            if (bus1.o_mem_rd_en) nrd++;
        end
        chk("stall_reads", 32'(nrd), 4);
        chk("stall_level", 32'(level), 4);
        chk("stall_rd_en", 32'(bus1.o_mem_rd_en), 0);
        chk("stall_inst",  bus1.o_inst, 32'hC000_0200);
        chk("stall_pcn",   bus1.o_inst_pc_next, 32'h204);
        cyc(1,1,0,0);
        chk("full_deq_rd_en", 32'(bus1.o_mem_rd_en), 0);
        chk("full_deq_valid", 32'(bus1.o_inst_valid), 1);
        nrd = 0; last_rd_addr = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(0,1,0,0);
            if (bus1.o_mem_rd_en) begin nrd++; last_rd_addr = bus1.o_mem_addr; end
        end
        chk("refill_reads", 32'(nrd), 1);
        chk("refill_addr",  last_rd_addr, 32'h210);
        chk("refill_level", 32'(level), 4);
        chk("refill_inst",  bus1.o_inst, 32'hC000_0204);

        // Redirect with 3 queued entries and one read in flight.
        cyc(0,1,1,32'h300);
        for (int i = 0; i < 5; i++) cyc(0,1,0,0);
        chk("pre_redir_level", 32'(level), 3);
        cyc(0,1,1,32'h100);
        chk("redir_valid", 32'(bus1.o_inst_valid), 0);
        chk("redir_rd_en", 32'(bus1.o_mem_rd_en), 0);
        cyc(1,1,0,0);
        chk("post_redir_level", 32'(level), 0);
        chk("post_redir_rd_en", 32'(bus1.o_mem_rd_en), 1);
        chk("post_redir_addr",  bus1.o_mem_addr, 32'h100);
        cyc(1,1,0,0);
        chk("post_redir_valid1", 32'(bus1.o_inst_valid), 0);
        cyc(1,1,0,0);
        chk("tgt0_valid", 32'(bus1.o_inst_valid), 1);
        chk("tgt0_inst",  bus1.o_inst, 32'hC000_0100);
        chk("tgt0_pcn",   bus1.o_inst_pc_next, 32'h104);
        cyc(1,1,0,0);
        chk("tgt1_inst",  bus1.o_inst, 32'hC000_0104);
        cyc(1,1,0,0);
        chk("tgt2_inst",  bus1.o_inst, 32'hC000_0108);

        // Reset pulse mid-stream.
        cyc(0,1,1,32'h500);
        for (int i = 0; i < 5; i++) cyc(0,1,0,0);
        chk("pre_rst_level", 32'(level), 3);
        @(negedge clk); rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1; enable = 1'b0; #1;
        chk("mid_rst_rd_en",  32'(bus1.o_mem_rd_en), 0);
        chk("mid_rst_addr",   bus1.o_mem_addr, 0);
        chk("mid_rst_valid",  32'(bus1.o_inst_valid), 0);
        chk("mid_rst_inst",   bus1.o_inst, 0);
        chk("mid_rst_pcn",    bus1.o_inst_pc_next, 0);
        chk("mid_rst_halted", 32'(halted), 0);
        chk("mid_rst_level",  32'(level), 0);
        cyc(1,1,0,0);
        chk("restart_rd_en", 32'(bus1.o_mem_rd_en), 1);
        chk("restart_addr",  bus1.o_mem_addr, 0);
        cyc(1,1,0,0);
        chk("restart_addr1", bus1.o_mem_addr, 4);
        chk("restart_valid", 32'(bus1.o_inst_valid), 0);
        cyc(1,1,0,0);
        chk("restart_inst",  bus1.o_inst, 32'h11);
        chk("restart_pcn",   bus1.o_inst_pc_next, 4);

        // 8-bit PC wrap on the second instance.
        @(negedge clk); rst2_n = 1'b1; enable2 = 1'b1; bus2.i_inst_ready = 1'b1; #1;
        chk("wrap_rd_en0", 32'(bus2.o_mem_rd_en), 1);
        chk("wrap_addr0",  32'(bus2.o_mem_addr), 32'hFC);
        @(negedge clk); #1;
        chk("wrap_addr1",  32'(bus2.o_mem_addr), 32'h00);
        @(negedge clk); #1;
        chk("wrap_valid",  32'(bus2.o_inst_valid), 1);
        chk("wrap_inst0",  bus2.o_inst, 32'hD000_00FC);
        chk("wrap_pcn0",   32'(bus2.o_inst_pc_next), 32'h00);
        @(negedge clk); #1;
        chk("wrap_inst1",  bus2.o_inst, 32'hD000_0000);
        chk("wrap_pcn1",   32'(bus2.o_inst_pc_next), 32'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
